// File: rtl/dm_param.sv
// Parametrised MIPS data memory: byte/half/word loads and stores with a registered
// read path, programmable wait states and a req/done handshake.
module dm_param #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        done,
    output logic        err,
    output logic        busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_reg;
    logic [3:0]          cnt_reg;
    logic                we_reg;
    logic [5:0]          op_reg;
    logic [ADDR_W-1:0]   idx_reg;
    logic [1:0]          lane_reg;
    logic [31:0]         din_reg;
    logic [31:0]         dout_reg;
    logic                done_reg;
    logic                err_reg;

    // Contents start at zero once; rst deliberately leaves them alone.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    logic        is_load, is_store, sext;
    logic [1:0]  size;
    logic        misalign, bad, complete, do_write;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rword;
    logic [31:0] load_val;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sext     = 1'b0;
        size     = SZ_W;
        case (op_reg)
            6'b100000: begin is_load  = 1'b1; size = SZ_B; sext = 1'b1; end
            6'b100001: begin is_load  = 1'b1; size = SZ_H; sext = 1'b1; end
            6'b100011: begin is_load  = 1'b1; size = SZ_W; end
            6'b100100: begin is_load  = 1'b1; size = SZ_B; end
            6'b100101: begin is_load  = 1'b1; size = SZ_H; end
            6'b101000: begin is_store = 1'b1; size = SZ_B; end
            6'b101001: begin is_store = 1'b1; size = SZ_H; end
            6'b101011: begin is_store = 1'b1; size = SZ_W; end
            default:   ;
        endcase
    end

    assign misalign = ((size == SZ_H) && lane_reg[0]) || ((size == SZ_W) && (lane_reg != 2'b00));
    assign bad      = !(is_load || is_store) || (is_load && we_reg) || (is_store && !we_reg) || misalign;
    assign complete = (state_reg == ACCESS) && (cnt_reg == 4'd0);
    assign do_write = complete && !bad && is_store;

    // Store data is replicated across lanes so each byte enable picks its own slice.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign be[gi] = (size == SZ_B) ? (lane_reg == 2'(gi)) :
                        (size == SZ_H) ? (lane_reg[1] == 1'(gi / 2)) : 1'b1;
        assign wdata[8*gi +: 8] = (size == SZ_B) ? din_reg[7:0] :
                                  (size == SZ_H) ? din_reg[8*(gi % 2) +: 8] :
                                                   din_reg[8*gi +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx_reg][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rword = mem[idx_reg];

    always_comb begin
        load_val = rword;
        case (size)
            SZ_B: begin
                load_val = {24'h0, rword[{lane_reg, 3'b000} +: 8]};
                if (sext) load_val[31:8] = {24{load_val[7]}};
            end
            SZ_H: begin
                load_val = {16'h0, rword[{lane_reg[1], 4'b0000} +: 16]};
                if (sext) load_val[31:16] = {16{load_val[15]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            op_reg    <= 6'd0;
            idx_reg   <= '0;
            lane_reg  <= 2'b00;
            din_reg   <= 32'h0;
            dout_reg  <= 32'h0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        we_reg    <= we;
                        op_reg    <= op;
                        idx_reg   <= addr[ADDR_W+1:2];
                        lane_reg  <= addr[1:0];
                        din_reg   <= din;
                        cnt_reg   <= 4'(WAIT_CYCLES);
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                        err_reg   <= bad;
                        dout_reg  <= (!bad && is_load) ? load_val : 32'h0;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign dout = dout_reg;
    assign done = done_reg;
    assign err  = err_reg;
    assign busy = (state_reg != IDLE);
endmodule

// File: tb/tb_dm_param.sv
// Directed bench for dm_param: instance 0 has no wait states, instance 1 has three.
module tb_dm_param;
    localparam logic [5:0] LB  = 6'b100000, LH  = 6'b100001, LW = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100, LHU = 6'b100101;
    localparam logic [5:0] SB  = 6'b101000, SH  = 6'b101001, SW = 6'b101011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we  = 2'b00;
    logic [5:0]  op   [2];
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic [1:0]  done, err, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dm_param #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .op(op[0]), .addr(addr[0]),
        .din(din[0]), .dout(dout[0]), .done(done[0]), .err(err[0]), .busy(busy[0])
    );

    dm_param #(.ADDR_W(10), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .op(op[1]), .addr(addr[1]),
        .din(din[1]), .dout(dout[1]), .done(done[1]), .err(err[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access: lat counts posedges from the req edge to the one that raised done.
    task automatic acc(input int d, input logic w, input logic [5:0] o,
                       input logic [31:0] a, input logic [31:0] di,
                       output logic [31:0] q, output logic e, output int lat);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; op[d] = o; addr[d] = a; din[d] = di;
        @(posedge clk); #1;
        req[d] = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done[d]) break;
        end
        q = dout[d];
        e = err[d];
        $display("acc dut%0d we=%0b op=%06b addr=0x%08h din=0x%08h -> dout=0x%08h err=%0b lat=%0d",
                 d, w, o, a, di, q, e, lat);
    endtask

    logic [31:0] q;
    logic        e;
    int          lat, busy_cnt, done_cnt, done_at;

    initial begin
        for (int i = 0; i < 2; i++) begin
            op[i] = 6'd0; addr[i] = 32'h0; din[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_done0", {30'h0, done}, 32'h0);
        check("rst_err0",  {30'h0, err},  32'h0);
        check("rst_busy0", {30'h0, busy}, 32'h0);
        check("rst_dout0", dout[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Word store/load with no wait states
        acc(0, 1'b1, SW, 32'h10, 32'h8899AABB, q, e, lat);
        check("sw_lat", lat, 1);
        check("sw_err", {31'h0, e}, 32'h0);
        acc(0, 1'b0, LW, 32'h10, 32'h0, q, e, lat);
        check("lw_lat", lat, 1);
        check("lw_dout", q, 32'h8899AABB);
        check("lw_err", {31'h0, e}, 32'h0);

        // Byte lanes and extension
        acc(0, 1'b1, SB, 32'h13, 32'h000000F0, q, e, lat);
        acc(0, 1'b0, LW, 32'h10, 32'h0, q, e, lat);
        check("sb_lw", q, 32'hF099AABB);
        acc(0, 1'b0, LB, 32'h13, 32'h0, q, e, lat);
        check("lb", q, 32'hFFFFFFF0);
        acc(0, 1'b0, LBU, 32'h13, 32'h0, q, e, lat);
        check("lbu", q, 32'h000000F0);
        acc(0, 1'b0, LH, 32'h12, 32'h0, q, e, lat);
        check("lh", q, 32'hFFFFF099);
        acc(0, 1'b0, LHU, 32'h10, 32'h0, q, e, lat);
        check("lhu", q, 32'h0000AABB);

        // Misalignment and illegal combinations
        acc(0, 1'b1, SW, 32'h11, 32'h12345678, q, e, lat);
        check("sw_mis_err", {31'h0, e}, 32'h1);
        check("sw_mis_dout", q, 32'h0);
        acc(0, 1'b0, LW, 32'h10, 32'h0, q, e, lat);
        check("sw_mis_nowr", q, 32'hF099AABB);
        acc(0, 1'b0, LH, 32'h11, 32'h0, q, e, lat);
        check("lh_mis_err", {31'h0, e}, 32'h1);
        acc(0, 1'b1, 6'b000000, 32'h10, 32'h11111111, q, e, lat);
        check("illegal_err", {31'h0, e}, 32'h1);
        acc(0, 1'b1, LW, 32'h10, 32'h22222222, q, e, lat);
        check("ld_we_err", {31'h0, e}, 32'h1);
        acc(0, 1'b0, SW, 32'h10, 32'h33333333, q, e, lat);
        check("st_nowe_err", {31'h0, e}, 32'h1);
        acc(0, 1'b0, LW, 32'h10, 32'h0, q, e, lat);
        check("illegal_nowr", q, 32'hF099AABB);
        check("ok_err_clear", {31'h0, e}, 32'h0);

        // Halfword store into upper half
        acc(0, 1'b1, SW, 32'h30, 32'h01020304, q, e, lat);
        acc(0, 1'b1, SH, 32'h32, 32'hABCD7E01, q, e, lat);
        acc(0, 1'b0, LW, 32'h30, 32'h0, q, e, lat);
        check("sh_lw", q, 32'h7E010304);
        acc(0, 1'b0, LB, 32'h31, 32'h0, q, e, lat);
        check("lb_pos", q, 32'h00000003);
        acc(0, 1'b0, LH, 32'h30, 32'h0, q, e, lat);
        check("lh_pos", q, 32'h00000304);

        // Address wrap at 4 KB
        acc(0, 1'b1, SW, 32'h1004, 32'hCAFEF00D, q, e, lat);
        acc(0, 1'b0, LW, 32'h0004, 32'h0, q, e, lat);
        check("wrap", q, 32'hCAFEF00D);

        // Wait states: latency, ignored req while busy, back-to-back
        acc(1, 1'b1, SW, 32'h10, 32'h11112222, q, e, lat);
        check("w3_sw_lat", lat, 4);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; op[1] = LW; addr[1] = 32'h10;
        @(posedge clk); #1;
        req[1] = 1'b0;
        busy_cnt = int'(busy[1]);
        done_cnt = 0;
        done_at  = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req[1] = (c == 1);
            we[1] = 1'b1; op[1] = SW; addr[1] = 32'h10; din[1] = 32'hDEADBEEF;
            @(posedge clk); #1;
            busy_cnt += int'(busy[1]);
            if (done[1]) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = c + 1;
                    check("w3_lw_dout", dout[1], 32'h11112222);
                end
            end
        end
        req[1] = 1'b0;
        check("w3_busy_cycles", busy_cnt, 4);
        check("w3_done_at", done_at, 4);
        check("w3_one_done", done_cnt, 1);
        acc(1, 1'b0, LW, 32'h10, 32'h0, q, e, lat);
        check("w3_ignored_nowr", q, 32'h11112222);
        acc(1, 1'b0, LW, 32'h10, 32'h0, q, e, lat);
        check("w3_b2b_lat", lat, 4);

        // Reset in the middle of a store
        acc(1, 1'b1, SW, 32'h20, 32'hAAAA5555, q, e, lat);
        acc(1, 1'b0, LW, 32'h20, 32'h0, q, e, lat);
        check("w3_pre_rst", q, 32'hAAAA5555);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; op[1] = SW; addr[1] = 32'h20; din[1] = 32'h12345678;
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_busy", {31'h0, busy[1]}, 32'h0);
        check("rst_mid_dout", dout[1], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            done_cnt += int'(done[1]);
        end
        check("rst_mid_nodone", done_cnt, 0);
        acc(1, 1'b0, LW, 32'h20, 32'h0, q, e, lat);
        check("rst_mid_nowr", q, 32'hAAAA5555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
